pong_match_ctrl: RTL and testbench

Match sequencer for the pong datapath: owns the rally/serve/score state and gates the ball-movement logic. It sits between the debounced player inputs, the ball/paddle datapath (which reports misses and consumes enable/recentre/serve-direction), and the 7-segment score display. It removes scoring and reset decisions from the ball datapath, leaving that path purely positional.

---
 rtl/pong_pkg.sv | 20 ++
 rtl/tick_timer.sv | 33 +++
 rtl/pong_match_ctrl.sv | 153 +++++++++++++++
 tb/tb_pong_match_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state, winner and serve-direction encodings for the pong match sequencer
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_POINT = 3'd4,
        ST_OVER  = 3'd5
    } state_e;

    localparam logic [1:0] WINNER_NONE  = 2'b00;
    localparam logic [1:0] WINNER_LEFT  = 2'b01;
    localparam logic [1:0] WINNER_RIGHT = 2'b10;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - 8-bit load/decrement-on-enable down-counter with expiry flag
module tick_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       en,
    input  logic [7:0] load_val,
    output logic       done
);

    logic [7:0] count_q, count_d;

    // done marks the edge on which the count reaches zero, so the caller can react on that same edge
    assign done = en && !load && (count_q == 8'd1);

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != 8'd0)) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - pong match sequencer: serve/rally/point/score state and ball gating
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_TICKS = 60,
    parameter int POINT_TICKS = 30
) (
    input  logic       iclk,
    input  logic       ireset,
    input  logic       iTick,
    input  logic       iStart,
    input  logic       iPause,
    input  logic       iMissL,
    input  logic       iMissR,
    output logic       oBallEn,
    output logic       oBallRecentre,
    output logic       oServeDir,
    output logic [3:0] oScoreL,
    output logic [3:0] oScoreR,
    output logic [1:0] oWinner,
    output logic [2:0] oState
);

    localparam logic [3:0] WIN4   = WIN_SCORE[3:0];
    localparam logic [7:0] SERVE8 = SERVE_TICKS[7:0];
    localparam logic [7:0] POINT8 = POINT_TICKS[7:0];

    state_e     state_q, state_d;
    logic [3:0] score_l_q, score_l_d;
    logic [3:0] score_r_q, score_r_d;
    logic [1:0] winner_q, winner_d;
    logic       dir_q, dir_d;
    logic       recentre_q, recentre_d;
    logic       ball_en_q, ball_en_d;
    logic       entry_q, entry_d;

    logic       timer_load;
    logic       timer_en;
    logic       timer_done;
    logic [7:0] timer_val;

    // The counter loads during the entry cycle, so a tick on that cycle is never counted
    assign timer_load = entry_q;
    assign timer_en   = iTick && !entry_q && ((state_q == ST_SERVE) || (state_q == ST_POINT));
    assign timer_val  = (state_q == ST_POINT) ? POINT8 : SERVE8;

    tick_timer u_tick_timer (
        .clk      (iclk),
        .reset    (ireset),
        .load     (timer_load),
        .en       (timer_en),
        .load_val (timer_val),
        .done     (timer_done)
    );

    always_comb begin
        state_d    = state_q;
        score_l_d  = score_l_q;
        score_r_d  = score_r_q;
        winner_d   = winner_q;
        dir_d      = dir_q;
        recentre_d = 1'b0;
        entry_d    = 1'b0;

        if (iStart) begin
            state_d    = ST_SERVE;
            score_l_d  = 4'd0;
            score_r_d  = 4'd0;
            winner_d   = WINNER_NONE;
            dir_d      = DIR_RIGHT;
            recentre_d = 1'b1;
            entry_d    = 1'b1;
        end else begin
            case (state_q)
                ST_SERVE: begin
                    if (timer_done) state_d = ST_PLAY;
                end
                ST_PLAY: begin
                    if (iMissL && iMissR) begin
                        state_d    = ST_SERVE;
                        recentre_d = 1'b1;
                        entry_d    = 1'b1;
                    end else if (iMissL) begin
                        state_d   = ST_POINT;
                        entry_d   = 1'b1;
                        dir_d     = DIR_LEFT;
                        score_r_d = (score_r_q == WIN4) ? score_r_q : score_r_q + 4'd1;
                    end else if (iMissR) begin
                        state_d   = ST_POINT;
                        entry_d   = 1'b1;
                        dir_d     = DIR_RIGHT;
                        score_l_d = (score_l_q == WIN4) ? score_l_q : score_l_q + 4'd1;
                    end else if (iPause) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (iPause) state_d = ST_PLAY;
                end
                ST_POINT: begin
                    if (timer_done) begin
                        if (score_l_q == WIN4) begin
                            state_d  = ST_OVER;
                            winner_d = WINNER_LEFT;
                        end else if (score_r_q == WIN4) begin
                            state_d  = ST_OVER;
                            winner_d = WINNER_RIGHT;
                        end else begin
                            state_d    = ST_SERVE;
                            recentre_d = 1'b1;
                            entry_d    = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        ball_en_d = (state_d == ST_PLAY);
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state_q    <= ST_IDLE;
            score_l_q  <= 4'd0;
            score_r_q  <= 4'd0;
            winner_q   <= WINNER_NONE;
            dir_q      <= DIR_RIGHT;
            recentre_q <= 1'b0;
            ball_en_q  <= 1'b0;
            entry_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            score_l_q  <= score_l_d;
            score_r_q  <= score_r_d;
            winner_q   <= winner_d;
            dir_q      <= dir_d;
            recentre_q <= recentre_d;
            ball_en_q  <= ball_en_d;
            entry_q    <= entry_d;
        end
    end

    assign oBallEn       = ball_en_q;
    assign oBallRecentre = recentre_q;
    assign oServeDir     = dir_q;
    assign oScoreL       = score_l_q;
    assign oScoreR       = score_r_q;
    assign oWinner       = winner_q;
    assign oState        = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb/tb_pong_match_ctrl.sv - directed self-checking bench for pong_match_ctrl
module tb_pong_match_ctrl;

    logic       iclk = 1'b0;
    logic       ireset = 1'b1;
    logic       iTick = 1'b0;
    logic       iStart = 1'b0;
    logic       iPause = 1'b0;
    logic       iMissL = 1'b0;
    logic       iMissR = 1'b0;
    logic       oBallEn;
    logic       oBallRecentre;
    logic       oServeDir;
    logic [3:0] oScoreL;
    logic [3:0] oScoreR;
    logic [1:0] oWinner;
    logic [2:0] oState;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2,
                           S_PAUSE = 3'd3, S_POINT = 3'd4, S_OVER = 3'd5;

    pong_match_ctrl #(.WIN_SCORE(9), .SERVE_TICKS(60), .POINT_TICKS(30)) dut (
        .iclk          (iclk),
        .ireset        (ireset),
        .iTick         (iTick),
        .iStart        (iStart),
        .iPause        (iPause),
        .iMissL        (iMissL),
        .iMissR        (iMissR),
        .oBallEn       (oBallEn),
        .oBallRecentre (oBallRecentre),
        .oServeDir     (oServeDir),
        .oScoreL       (oScoreL),
        .oScoreR       (oScoreR),
        .oWinner       (oWinner),
        .oState        (oState)
    );

    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1ns after the edge that registers them
    task automatic step(input logic start, input logic pause, input logic ml, input logic mr, input logic tick);
        iStart = start; iPause = pause; iMissL = ml; iMissR = mr; iTick = tick;
        @(posedge iclk);
        #1;
        iStart = 0; iPause = 0; iMissL = 0; iMissR = 0; iTick = 0;
        if (oBallRecentre) pulses++;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 8'(oState), 8'(S_IDLE));
        chk({tag, "_ballen"}, 8'(oBallEn), 8'd0);
        chk({tag, "_recentre"}, 8'(oBallRecentre), 8'd0);
        chk({tag, "_dir"}, 8'(oServeDir), 8'd0);
        chk({tag, "_scorel"}, 8'(oScoreL), 8'd0);
        chk({tag, "_scorer"}, 8'(oScoreR), 8'd0);
        chk({tag, "_winner"}, 8'(oWinner), 8'd0);
    endtask

    initial begin
        repeat (2) @(posedge iclk);
        #1 ireset = 1'b0;
        chk_reset_vals("rst");

        // Start, with a tick on the same cycle that must not matter
        step(1, 0, 0, 0, 1);
        chk("start_state", 8'(oState), 8'(S_SERVE));
        chk("start_recentre", 8'(oBallRecentre), 8'd1);
        pulses = 0;
        step(0, 0, 0, 0, 1);   // tick on entry cycle: ignored
        ticks(59);
        chk("serve59_state", 8'(oState), 8'(S_SERVE));
        chk("serve59_ballen", 8'(oBallEn), 8'd0);
        ticks(1);
        chk("serve60_state", 8'(oState), 8'(S_PLAY));
        chk("serve60_ballen", 8'(oBallEn), 8'd1);
        chk("serve_extra_pulses", 8'(pulses), 8'd0);

        step(0, 0, 1, 0, 0);
        chk("missl_state", 8'(oState), 8'(S_POINT));
        chk("missl_scorer", 8'(oScoreR), 8'd1);
        chk("missl_scorel", 8'(oScoreL), 8'd0);
        chk("missl_ballen", 8'(oBallEn), 8'd0);
        chk("missl_dir", 8'(oServeDir), 8'd1);
        step(0, 0, 0, 0, 1);   // entry tick ignored
        ticks(29);
        chk("point29_state", 8'(oState), 8'(S_POINT));
        ticks(1);
        chk("point30_state", 8'(oState), 8'(S_SERVE));
        chk("point30_recentre", 8'(oBallRecentre), 8'd1);
        step(0, 0, 0, 0, 0);
        chk("recentre_one_cycle", 8'(oBallRecentre), 8'd0);
        ticks(60);
        chk("serve2_state", 8'(oState), 8'(S_PLAY));

        step(0, 0, 1, 1, 0);
        chk("dbl_state", 8'(oState), 8'(S_SERVE));
        chk("dbl_recentre", 8'(oBallRecentre), 8'd1);
        chk("dbl_scores", {oScoreL, oScoreR}, 8'h01);
        chk("dbl_dir", 8'(oServeDir), 8'd1);
        chk("dbl_ballen", 8'(oBallEn), 8'd0);
        step(0, 0, 0, 0, 0);
        ticks(60);
        chk("serve3_state", 8'(oState), 8'(S_PLAY));

        step(0, 1, 0, 0, 0);
        chk("pause_state", 8'(oState), 8'(S_PAUSE));
        chk("pause_ballen", 8'(oBallEn), 8'd0);
        ticks(20);
        step(0, 0, 0, 1, 0);
        chk("pause_miss_state", 8'(oState), 8'(S_PAUSE));
        chk("pause_miss_scores", {oScoreL, oScoreR}, 8'h01);
        step(0, 1, 0, 0, 0);
        chk("resume_state", 8'(oState), 8'(S_PLAY));
        chk("resume_ballen", 8'(oBallEn), 8'd1);

        for (int i = 0; i < 9; i++) begin
            step(0, 0, 0, 1, 0);
            chk("rally_scorel", 8'(oScoreL), 8'(i + 1));
            chk("rally_state", 8'(oState), 8'(S_POINT));
            chk("rally_dir", 8'(oServeDir), 8'd0);
            step(0, 0, 0, 0, 0);
            ticks(30);
            if (i < 8) begin
                chk("rally_serve", 8'(oState), 8'(S_SERVE));
                step(0, 0, 0, 0, 0);
                ticks(60);
                chk("rally_play", 8'(oState), 8'(S_PLAY));
            end
        end
        chk("over_state", 8'(oState), 8'(S_OVER));
        chk("over_winner", 8'(oWinner), 8'h01);
        chk("over_ballen", 8'(oBallEn), 8'd0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 1);
        chk("over_scores_held", {oScoreL, oScoreR}, 8'h91);
        chk("over_state_held", 8'(oState), 8'(S_OVER));

        step(1, 0, 0, 0, 0);
        chk("restart_state", 8'(oState), 8'(S_SERVE));
        chk("restart_scores", {oScoreL, oScoreR}, 8'h00);
        chk("restart_winner", 8'(oWinner), 8'h00);
        chk("restart_dir", 8'(oServeDir), 8'd0);
        chk("restart_recentre", 8'(oBallRecentre), 8'd1);
        step(0, 0, 0, 0, 0);
        ticks(60);
        chk("restart_play", 8'(oState), 8'(S_PLAY));

        // Start outranks a miss in the same cycle
        step(1, 0, 1, 0, 0);
        chk("prio_state", 8'(oState), 8'(S_SERVE));
        chk("prio_scorer", 8'(oScoreR), 8'd0);
        step(0, 0, 0, 0, 0);
        ticks(60);
        step(0, 0, 1, 0, 0);
        chk("pre_rst_state", 8'(oState), 8'(S_POINT));
        chk("pre_rst_scorer", 8'(oScoreR), 8'd1);
        step(0, 0, 0, 0, 0);
        ticks(10);
        ireset = 1'b1;
        step(0, 0, 0, 0, 1);
        ireset = 1'b0;
        chk_reset_vals("midrst");
        step(1, 0, 0, 0, 0);
        chk("post_rst_state", 8'(oState), 8'(S_SERVE));
        chk("post_rst_recentre", 8'(oBallRecentre), 8'd1);
        step(0, 0, 0, 0, 0);
        ticks(60);
        chk("post_rst_play", 8'(oState), 8'(S_PLAY));
        chk("post_rst_scores", {oScoreL, oScoreR}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
